// File: rtl/ivs_frm_addr_gen.sv
// ivs_frm_addr_gen: emits one DMA line read request per cycle for a block-tiled frame.
// Optional overflow abort: define IVS_FRM_ADDR_GEN_OVF_CHK_EN (adds the addr_err port).
`timescale 1ns/1ps
module ivs_frm_addr_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] frm_i_base,
    input  logic [15:0] frm_line_stride,
    input  logic [15:0] frm_width,
    input  logic [15:0] frm_height,
    input  logic [15:0] frm_x_steps,
    input  logic [15:0] frm_y_steps,
    input  logic [15:0] frm_x_stride,
    input  logic [15:0] frm_y_stride,
    input  logic        rd_req_rdy,
    output logic        rd_req_vld,
    output logic [31:0] rd_req_addr,
    output logic [15:0] rd_req_len,
    output logic        blk_done,
    output logic        frm_done,
    output logic        busy
`ifdef IVS_FRM_ADDR_GEN_OVF_CHK_EN
    ,
    output logic        addr_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef IVS_FRM_ADDR_GEN_OVF_CHK_EN
    localparam int SW = 33;
`else
    localparam int SW = 32;
`endif

    state_t        state;
    state_t        state_nx;
    logic [15:0]   cfg_line_stride;
    logic [15:0]   cfg_height;
    logic [15:0]   cfg_x_steps;
    logic [15:0]   cfg_y_steps;
    logic [15:0]   cfg_x_stride;
    logic [15:0]   cfg_y_stride;
    logic [15:0]   line_cnt;
    logic [15:0]   bx_cnt;
    logic [15:0]   by_cnt;
    logic [31:0]   row_base;
    logic [31:0]   blk_base;
    logic [SW-1:0] line_sum;
    logic [SW-1:0] blk_sum;
    logic [SW-1:0] row_sum;
    logic          acc;
    logic          last_line;
    logic          last_bx;
    logic          last_by;
    logic          zero_cfg;
    logic          go;
    logic          ovf;

    assign rd_req_vld = (state == REQ);
    assign busy       = (state != IDLE);
    assign acc        = rd_req_vld & rd_req_rdy;
    assign go         = (state == IDLE) & start;
    assign zero_cfg   = (frm_height == 16'd0) | (frm_x_steps == 16'd0)
                      | (frm_y_steps == 16'd0);

    // Compare against count-1 so a 0xFFFF limit never needs a 17-bit counter.
    assign last_line = (line_cnt == cfg_height - 16'd1);
    assign last_bx   = (bx_cnt == cfg_x_steps - 16'd1);
    assign last_by   = (by_cnt == cfg_y_steps - 16'd1);

    assign line_sum = SW'(rd_req_addr) + SW'(cfg_line_stride);
    assign blk_sum  = SW'(blk_base) + SW'(cfg_x_stride);
    assign row_sum  = SW'(row_base) + SW'(cfg_y_stride);

`ifdef IVS_FRM_ADDR_GEN_OVF_CHK_EN
    // Carry out of whichever accumulator update this handshake performs.
    always_comb begin
        ovf = 1'b0;
        if (acc) begin
            if (!last_line) ovf = line_sum[SW-1];
            else if (!last_bx) ovf = blk_sum[SW-1];
            else if (!last_by) ovf = row_sum[SW-1];
        end
    end
`else
    assign ovf = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic: frame end or overflow abort leads to a one-cycle DONE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = zero_cfg ? DONE : REQ;
            REQ: begin
                if (acc && ((last_line && last_bx && last_by) || ovf))
                    state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Config latch, counters, address accumulators and done pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_line_stride <= '0;
            cfg_height      <= '0;
            cfg_x_steps     <= '0;
            cfg_y_steps     <= '0;
            cfg_x_stride    <= '0;
            cfg_y_stride    <= '0;
            rd_req_len      <= '0;
            rd_req_addr     <= '0;
            blk_base        <= '0;
            row_base        <= '0;
            line_cnt        <= '0;
            bx_cnt          <= '0;
            by_cnt          <= '0;
            blk_done        <= 1'b0;
            frm_done        <= 1'b0;
`ifdef IVS_FRM_ADDR_GEN_OVF_CHK_EN
            addr_err        <= 1'b0;
`endif
        end else begin
            blk_done <= acc & last_line;
            frm_done <= (go & zero_cfg) | ((state == REQ) & (state_nx == DONE));
            if (go) begin
                cfg_line_stride <= frm_line_stride;
                cfg_height      <= frm_height;
                cfg_x_steps     <= frm_x_steps;
                cfg_y_steps     <= frm_y_steps;
                cfg_x_stride    <= frm_x_stride;
                cfg_y_stride    <= frm_y_stride;
                rd_req_len      <= frm_width;
                rd_req_addr     <= frm_i_base;
                blk_base        <= frm_i_base;
                row_base        <= frm_i_base;
                line_cnt        <= '0;
                bx_cnt          <= '0;
                by_cnt          <= '0;
`ifdef IVS_FRM_ADDR_GEN_OVF_CHK_EN
                addr_err        <= 1'b0;
`endif
            end else if (acc && !ovf) begin
                if (!last_line) begin
                    line_cnt    <= line_cnt + 16'd1;
                    rd_req_addr <= line_sum[31:0];
                end else if (!last_bx) begin
                    line_cnt    <= '0;
                    bx_cnt      <= bx_cnt + 16'd1;
                    blk_base    <= blk_sum[31:0];
                    rd_req_addr <= blk_sum[31:0];
                end else if (!last_by) begin
                    line_cnt    <= '0;
                    bx_cnt      <= '0;
                    by_cnt      <= by_cnt + 16'd1;
                    row_base    <= row_sum[31:0];
                    blk_base    <= row_sum[31:0];
                    rd_req_addr <= row_sum[31:0];
                end
            end
`ifdef IVS_FRM_ADDR_GEN_OVF_CHK_EN
            if (ovf) addr_err <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_ivs_frm_addr_gen.sv
// tb_ivs_frm_addr_gen: randomized bench for ivs_frm_addr_gen against a loop-nest model.
// Honours IVS_FRM_ADDR_GEN_OVF_CHK_EN the same way as the design.
`timescale 1ns/1ps
module tb_ivs_frm_addr_gen;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] frm_i_base;
    logic [15:0] frm_line_stride;
    logic [15:0] frm_width;
    logic [15:0] frm_height;
    logic [15:0] frm_x_steps;
    logic [15:0] frm_y_steps;
    logic [15:0] frm_x_stride;
    logic [15:0] frm_y_stride;
    logic        rd_req_rdy;
    logic        rd_req_vld;
    logic [31:0] rd_req_addr;
    logic [15:0] rd_req_len;
    logic        blk_done;
    logic        frm_done;
    logic        busy;
`ifdef IVS_FRM_ADDR_GEN_OVF_CHK_EN
    logic        addr_err;
    bit          exp_err;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] c_base;
    logic [15:0] c_ls, c_w, c_h, c_xs, c_ys, c_xst, c_yst;
    logic [31:0] eq_addr[$];
    bit          eq_blk[$];

    ivs_frm_addr_gen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .frm_i_base      (frm_i_base),
        .frm_line_stride (frm_line_stride),
        .frm_width       (frm_width),
        .frm_height      (frm_height),
        .frm_x_steps     (frm_x_steps),
        .frm_y_steps     (frm_y_steps),
        .frm_x_stride    (frm_x_stride),
        .frm_y_stride    (frm_y_stride),
        .rd_req_rdy      (rd_req_rdy),
        .rd_req_vld      (rd_req_vld),
        .rd_req_addr     (rd_req_addr),
        .rd_req_len      (rd_req_len),
        .blk_done        (blk_done),
        .frm_done        (frm_done),
        .busy            (busy)
`ifdef IVS_FRM_ADDR_GEN_OVF_CHK_EN
        ,
        .addr_err        (addr_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_basic();
        c_base = 32'h1000; c_ls = 16'h100; c_w = 16'd64; c_h = 16'd2;
        c_xs = 16'd2; c_ys = 16'd1; c_xst = 16'h40; c_yst = 16'h0;
    endtask

    task automatic drive_cfg();
        frm_i_base = c_base; frm_line_stride = c_ls; frm_width = c_w;
        frm_height = c_h; frm_x_steps = c_xs; frm_y_steps = c_ys;
        frm_x_stride = c_xst; frm_y_stride = c_yst;
    endtask

    task automatic scramble_cfg();
        frm_i_base = $urandom; frm_line_stride = 16'($urandom);
        frm_width = 16'($urandom); frm_height = 16'($urandom);
        frm_x_steps = 16'($urandom); frm_y_steps = 16'($urandom);
        frm_x_stride = 16'($urandom); frm_y_stride = 16'($urandom);
    endtask

    // Exact request addresses in scan order; an address that no longer fits
    // 32 bits either wraps or (with the overflow check) ends the frame.
    task automatic build_model();
        longint unsigned a;
        bit stop;
        stop = 0;
        eq_addr.delete();
        eq_blk.delete();
`ifdef IVS_FRM_ADDR_GEN_OVF_CHK_EN
        exp_err = 0;
`endif
        if (c_h != 0 && c_xs != 0 && c_ys != 0) begin
            for (int by = 0; by < int'(c_ys) && !stop; by++)
                for (int bx = 0; bx < int'(c_xs) && !stop; bx++)
                    for (int l = 0; l < int'(c_h) && !stop; l++) begin
                        a = 64'(c_base) + 64'(by) * 64'(c_yst)
                          + 64'(bx) * 64'(c_xst) + 64'(l) * 64'(c_ls);
`ifdef IVS_FRM_ADDR_GEN_OVF_CHK_EN
                        if (a >= 64'h1_0000_0000) begin
                            stop = 1;
                            exp_err = 1;
                        end
`endif
                        if (!stop) begin
                            eq_addr.push_back(a[31:0]);
                            eq_blk.push_back(l == int'(c_h) - 1);
                        end
                    end
        end
    endtask

    function automatic logic rdy_pat(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return 1'(cyc % 2);
        return 1'($urandom % 2);
    endfunction

    // Start a frame from c_*, then check every cycle until frm_done.
    task automatic run_frame(input string tag, input int mode, input bit poke);
        int cyc;
        bit seen, eb, ef;
        build_model();
        @(posedge clk); #1;
        drive_cfg();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble_cfg();
        rd_req_rdy = rdy_pat(mode, 0);
        cyc = 0; seen = 0; eb = 0;
        ef = (eq_addr.size() == 0);
        while (!seen && cyc < 4000) begin
            @(negedge clk);
            total += 4;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL %s busy cyc=%0d got=%b want=1", tag, cyc, busy);
            end
            if (blk_done !== eb) begin
                bad++;
                $display("FAIL %s blk_done cyc=%0d got=%b want=%b", tag, cyc, blk_done, eb);
            end
            if (frm_done !== ef) begin
                bad++;
                $display("FAIL %s frm_done cyc=%0d got=%b want=%b", tag, cyc, frm_done, ef);
            end
            if (rd_req_vld !== (eq_addr.size() != 0)) begin
                bad++;
                $display("FAIL %s vld cyc=%0d got=%b want=%b", tag, cyc,
                         rd_req_vld, eq_addr.size() != 0);
            end
            seen = ef; eb = 0; ef = 0;
            if (rd_req_vld === 1'b1 && eq_addr.size() != 0) begin
                total++;
                if (rd_req_addr !== eq_addr[0] || rd_req_len !== c_w) begin
                    bad++;
                    $display("FAIL %s req cyc=%0d got=%h/%0d want=%h/%0d", tag, cyc,
                             rd_req_addr, rd_req_len, eq_addr[0], c_w);
                end
                if (rd_req_rdy) begin
                    eb = eq_blk[0];
                    ef = (eq_addr.size() == 1);
                    void'(eq_addr.pop_front());
                    void'(eq_blk.pop_front());
                end
            end
            @(posedge clk); #1;
            cyc++;
            rd_req_rdy = rdy_pat(mode, cyc);
            start = poke && (cyc == 1);
            if (start) scramble_cfg();
        end
        start = 1'b0;
        if (!seen) begin
            total++; bad++;
            $display("FAIL %s timeout got=no_frm_done want=frm_done", tag);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || rd_req_vld !== 1'b0) begin
            bad++;
            $display("FAIL %s idle got=busy%b/vld%b want=0/0", tag, busy, rd_req_vld);
        end
`ifdef IVS_FRM_ADDR_GEN_OVF_CHK_EN
        total++;
        if (addr_err !== exp_err) begin
            bad++;
            $display("FAIL %s addr_err got=%b want=%b", tag, addr_err, exp_err);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; rd_req_rdy = 1'b0;
        set_basic();
        drive_cfg();
        repeat (2) @(posedge clk);
        @(negedge clk);
        total += 3;
        if (rd_req_vld !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_ctl got=vld%b/busy%b want=0/0", rd_req_vld, busy);
        end
        if (rd_req_addr !== 32'h0 || rd_req_len !== 16'h0) begin
            bad++;
            $display("FAIL rst_req got=%h/%h want=0/0", rd_req_addr, rd_req_len);
        end
        if (blk_done !== 1'b0 || frm_done !== 1'b0) begin
            bad++;
            $display("FAIL rst_done got=%b/%b want=0/0", blk_done, frm_done);
        end
`ifdef IVS_FRM_ADDR_GEN_OVF_CHK_EN
        total++;
        if (addr_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_err got=%b want=0", addr_err);
        end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || rd_req_vld !== 1'b0) begin
            bad++;
            $display("FAIL rst_idle got=busy%b/vld%b want=0/0", busy, rd_req_vld);
        end
    endtask

    task automatic test_basic();
        set_basic();
        run_frame("basic", 0, 0);
    endtask

    task automatic test_2d();
        set_basic();
        c_ys = 16'd2; c_yst = 16'h200;
        run_frame("2d", 0, 0);
    endtask

    task automatic test_backpressure();
        set_basic();
        run_frame("bp", 1, 0);
    endtask

    task automatic test_zero();
        set_basic();
        c_xs = 16'd0;
        run_frame("zero_x", 0, 0);
        set_basic();
        c_h = 16'd0;
        run_frame("zero_h", 0, 0);
    endtask

    task automatic test_reset_mid();
        set_basic();
        @(posedge clk); #1;
        drive_cfg();
        start = 1'b1;
        rd_req_rdy = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        total++;
        if (rd_req_vld !== 1'b1 || rd_req_addr !== 32'h1040 || blk_done !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre got=%b/%h/%b want=1/00001040/1",
                     rd_req_vld, rd_req_addr, blk_done);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (rd_req_vld !== 1'b0 || rd_req_addr !== 32'h0 || rd_req_len !== 16'h0 ||
            blk_done !== 1'b0 || frm_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst got=%b/%h/%h/%b/%b/%b want=all_zero", rd_req_vld,
                     rd_req_addr, rd_req_len, blk_done, frm_done, busy);
        end
`ifdef IVS_FRM_ADDR_GEN_OVF_CHK_EN
        total++;
        if (addr_err !== 1'b0) begin
            bad++;
            $display("FAIL mid_err got=%b want=0", addr_err);
        end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || rd_req_vld !== 1'b0) begin
            bad++;
            $display("FAIL mid_noresume got=busy%b/vld%b want=0/0", busy, rd_req_vld);
        end
        set_basic();
        run_frame("restart_busy_start", 0, 1);
    endtask

    task automatic test_overflow();
        set_basic();
        c_base = 32'hFFFF_FF00; c_w = 16'd16; c_xs = 16'd1;
        run_frame("ovf", 0, 0);
        set_basic();
        run_frame("ovf_clear", 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            c_base = $urandom;
            c_ls = 16'($urandom); c_w = 16'($urandom);
            c_xst = 16'($urandom); c_yst = 16'($urandom);
            c_h = 16'($urandom_range(1, 3));
            c_xs = 16'($urandom_range(1, 3));
            c_ys = 16'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0: c_h = 16'd0;
                    1: c_xs = 16'd0;
                    default: c_ys = 16'd0;
                endcase
            end
            run_frame($sformatf("rand%0d", i), 2, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; rd_req_rdy = 1'b0;
        scramble_cfg();
        test_reset();
        test_basic();
        test_2d();
        test_backpressure();
        test_zero();
        test_reset_mid();
        test_overflow();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
